oled_spi_tx: RTL and testbench

//  Serial transmit stage downstream of the processor core: accepts {dc,byte} writes from the

---
 rtl/oled_spi_tx.sv | 182 ++++++++++++++++++
 tb/tb_oled_spi_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_tx.sv
// oled_spi_tx: {dc,byte} write FIFO feeding an SSD1306 4-wire SPI (mode 3) serialiser.
// Define OLED_PWRSEQ_EN to insert the vdd/res/vbat power-up sequencer ahead of IDLE.
module oled_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PWR_WAIT   = 1000
) (
  input  logic        sysclk,
  input  logic        cpu_reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_dc,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic [15:0] sent_cnt,
  output logic        oled_sclk,
  output logic        oled_sdin,
  output logic        oled_dc,
  output logic        oled_res,
  output logic        oled_vdd,
  output logic        oled_vbat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PH_RISE   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * CLK_DIV - 1);

  if (CLK_DIV < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PWR_WAIT < 1)
    begin : g_bad_params
      $error("oled_spi_tx: illegal parameter value");
    end

`ifdef OLED_PWRSEQ_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_PWR_VDD, ST_PWR_RES, ST_PWR_VBAT} state_t;
  localparam state_t RESET_STATE = ST_PWR_VDD;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t        state, state_next;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full, push, pop;
  logic [8:0]    head;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx, bit_next;
  logic [PW-1:0] phase;
  logic          sclk_rise, sclk_fall, byte_done, pwr_active;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL);
  assign head       = mem[rd_ptr];
  assign push       = wr_valid && wr_ready;
  assign wr_ready   = !fifo_full && !pwr_active;
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign bit_next   = bit_idx - 3'd1;

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= {wr_dc, wr_data};
  end

  // Occupancy is registered, so a freshly written entry is only visible to the popper next cycle.
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef OLED_PWRSEQ_EN
  localparam int WW = (PWR_WAIT > 1) ? $clog2(PWR_WAIT) : 1;
  localparam logic [WW-1:0] PWR_LAST = WW'(PWR_WAIT - 1);
  logic [WW-1:0] pwr_cnt;

  assign pwr_active = (state == ST_PWR_VDD) || (state == ST_PWR_RES) || (state == ST_PWR_VBAT);

  always_ff @(posedge sysclk) begin
    if (cpu_reset)       pwr_cnt <= '0;
    else if (pwr_active) pwr_cnt <= (pwr_cnt == PWR_LAST) ? '0 : pwr_cnt + 1'b1;
  end
`else
  assign pwr_active = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (cpu_reset) state <= RESET_STATE;
    else           state <= state_next;
  end

  // The last cycle of bit 0's high phase either reloads from the FIFO (no gap) or returns to IDLE.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    sclk_rise  = 1'b0;
    sclk_fall  = 1'b0;
    byte_done  = 1'b0;
    oled_vdd   = 1'b0;
    oled_res   = 1'b1;
    oled_vbat  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (phase == PH_RISE) begin
          sclk_rise = 1'b1;
        end else if (phase == PH_LAST) begin
          if (bit_idx != 3'd0) begin
            sclk_fall = 1'b1;
          end else begin
            byte_done = 1'b1;
            if (!fifo_empty) pop = 1'b1;
            else             state_next = ST_IDLE;
          end
        end
      end
`ifdef OLED_PWRSEQ_EN
      ST_PWR_VDD: begin
        oled_vbat = 1'b1;
        if (pwr_cnt == PWR_LAST) state_next = ST_PWR_RES;
      end
      ST_PWR_RES: begin
        oled_res  = 1'b0;
        oled_vbat = 1'b1;
        if (pwr_cnt == PWR_LAST) state_next = ST_PWR_VBAT;
      end
      ST_PWR_VBAT: begin
        if (pwr_cnt == PWR_LAST) state_next = ST_IDLE;
      end
`endif
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      shreg     <= '0;
      bit_idx   <= '0;
      phase     <= '0;
      oled_sclk <= 1'b1;
      oled_sdin <= 1'b0;
      oled_dc   <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      if (pop) begin
        shreg     <= head[7:0];
        oled_dc   <= head[8];
        oled_sdin <= head[7];
        oled_sclk <= 1'b0;
        bit_idx   <= 3'd7;
        phase     <= '0;
      end else if (sclk_fall) begin
        oled_sclk <= 1'b0;
        oled_sdin <= shreg[bit_next];
        bit_idx   <= bit_next;
        phase     <= '0;
      end else begin
        if (sclk_rise) oled_sclk <= 1'b1;
        if (state == ST_SHIFT) phase <= phase + 1'b1;
      end
      if (byte_done) sent_cnt <= sent_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// tb_oled_spi_tx: directed and randomized checks of oled_spi_tx using an SPI bus decoder and a
// {dc,byte} scoreboard; also covers the power-up sequencer when OLED_PWRSEQ_EN is defined.
`timescale 1ns/1ps
module tb_oled_spi_tx;

  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int PWR_WAIT   = 10;
  localparam int BYTE_CYC   = 16 * CLK_DIV;
`ifdef OLED_PWRSEQ_EN
  localparam logic RST_BUSY  = 1'b1;
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_BUSY  = 1'b0;
  localparam logic RST_READY = 1'b1;
`endif

  logic        sysclk = 1'b0;
  logic        cpu_reset, wr_valid, wr_ready, wr_dc, busy;
  logic [7:0]  wr_data;
  logic [15:0] sent_cnt;
  logic        oled_sclk, oled_sdin, oled_dc, oled_res, oled_vdd, oled_vbat;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_sent = 0;
  logic [8:0] exp_q[$];
  logic [8:0] rx_q[$];

  logic       prev_sclk = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       rx_dc = 1'b0;
  int         rx_bits = 0;
  int         seg_rises = 0;
  int         seg_first = -1;
  int         seg_last = 0;

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc++;

  oled_spi_tx #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .PWR_WAIT(PWR_WAIT)
  ) dut (
    .sysclk(sysclk), .cpu_reset(cpu_reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_dc(wr_dc), .wr_data(wr_data), .busy(busy), .sent_cnt(sent_cnt),
    .oled_sclk(oled_sclk), .oled_sdin(oled_sdin), .oled_dc(oled_dc),
    .oled_res(oled_res), .oled_vdd(oled_vdd), .oled_vbat(oled_vbat)
  );

  // SPI decoder: a byte is the 8 sdin values seen at sclk rising edges, dc taken at its first bit.
  always @(negedge sysclk) begin
    if (cpu_reset === 1'b1) begin
      rx_bits   = 0;
      prev_sclk = 1'b1;
    end else begin
      if (prev_sclk === 1'b0 && oled_sclk === 1'b1) begin
        rx_byte = {rx_byte[6:0], oled_sdin};
        if (rx_bits == 0) rx_dc = oled_dc;
        rx_bits++;
        seg_rises++;
        if (seg_first < 0) seg_first = cyc;
        seg_last = cyc;
        if (rx_bits == 8) begin
          rx_q.push_back({rx_dc, rx_byte});
          rx_bits = 0;
        end
      end
      prev_sclk = oled_sclk;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic applyStimulus(input logic dc, input logic [7:0] data, output bit accepted);
    wr_valid = 1'b1;
    wr_dc    = dc;
    wr_data  = data;
    accepted = 1'b0;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge sysclk);
      accepted = (wr_ready === 1'b1);
      tick();
    end
    if (accepted) begin
      exp_q.push_back({dc, data});
      model_sent++;
    end
    checkOutput($sformatf("write_accept_%02h", data), 32'(accepted), 1);
  endtask

  task automatic applyReset();
    cpu_reset = 1'b1;
    wr_valid  = 1'b0;
    tick();
    tick();
    cpu_reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
    model_sent = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sclk"}, 32'(oled_sclk), 1);
    checkOutput({tag, "_sdin"}, 32'(oled_sdin), 0);
    checkOutput({tag, "_dc"}, 32'(oled_dc), 0);
    checkOutput({tag, "_sent"}, 32'(sent_cnt), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'(RST_BUSY));
    checkOutput({tag, "_ready"}, 32'(wr_ready), 32'(RST_READY));
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    @(negedge sysclk);
    while (busy !== 1'b0 && n < 5000) begin
      tick();
      @(negedge sysclk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic compareStream(input string tag);
    int n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    checkOutput({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    checkOutput({tag, "_sent"}, 32'(sent_cnt), 32'(16'(model_sent)));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit ok;
    int acc;
    int n;
    cpu_reset = 1'b1;
    wr_valid  = 1'b0;
    wr_dc     = 1'b0;
    wr_data   = 8'h00;
    tick();
    applyReset();
    @(negedge sysclk);
    checkResetState("rst");

`ifdef OLED_PWRSEQ_EN
    // Writes offered during the power sequence must all be refused.
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    for (int k = 0; k <= 3 * PWR_WAIT; k++) begin
      if (k > 0) begin
        tick();
        if (k == 3 * PWR_WAIT - 1) wr_valid = 1'b0;
        @(negedge sysclk);
      end
      checkOutput($sformatf("pwr_vdd_%0d", k), 32'(oled_vdd), 0);
      checkOutput($sformatf("pwr_res_%0d", k), 32'(oled_res), 32'(!(k >= PWR_WAIT && k < 2 * PWR_WAIT)));
      checkOutput($sformatf("pwr_vbat_%0d", k), 32'(oled_vbat), 32'(k < 2 * PWR_WAIT));
      checkOutput($sformatf("pwr_ready_%0d", k), 32'(wr_ready), 32'(k >= 3 * PWR_WAIT));
    end
    waitIdle("pwr");
    checkOutput("pwr_sent", 32'(sent_cnt), 0);
    checkOutput("pwr_rx", rx_q.size(), 0);
    tick();
`else
    checkOutput("const_vdd", 32'(oled_vdd), 0);
    checkOutput("const_res", 32'(oled_res), 1);
    checkOutput("const_vbat", 32'(oled_vbat), 0);
    tick();
`endif

    // Single byte: latency, first bit, byte period, counter and busy.
    applyStimulus(1'b1, 8'hA5, ok);
    wr_valid = 1'b0;
    @(negedge sysclk);
    checkOutput("t1_sclk_pre", 32'(oled_sclk), 1);
    tick();
    @(negedge sysclk);
    checkOutput("t1_sclk_fall", 32'(oled_sclk), 0);
    checkOutput("t1_dc", 32'(oled_dc), 1);
    checkOutput("t1_bit7", 32'(oled_sdin), 1);
    repeat (BYTE_CYC - 1) tick();
    @(negedge sysclk);
    checkOutput("t1_sent_before", 32'(sent_cnt), 0);
    checkOutput("t1_busy_before", 32'(busy), 1);
    tick();
    @(negedge sysclk);
    checkOutput("t1_sent_after", 32'(sent_cnt), 1);
    checkOutput("t1_busy_after", 32'(busy), 0);
    checkOutput("t1_sclk_idle", 32'(oled_sclk), 1);
    tick();
    compareStream("t1");

    // Back-to-back: three consecutive writes produce a gap-free 24-edge burst.
    seg_rises = 0;
    seg_first = -1;
    applyStimulus(1'b0, 8'hAE, ok);
    applyStimulus(1'b0, 8'h81, ok);
    applyStimulus(1'b1, 8'hFF, ok);
    wr_valid = 1'b0;
    waitIdle("t2");
    checkOutput("t2_rises", seg_rises, 24);
    checkOutput("t2_span", seg_last - seg_first, 23 * 2 * CLK_DIV);
    tick();
    compareStream("t2");

    // FIFO full: 5 accepted (one popped immediately), next acceptance only after the first byte ends.
    acc      = 0;
    wr_valid = 1'b1;
    wr_dc    = 1'($urandom);
    wr_data  = 8'($urandom);
    for (int k = 0; k < 40; k++) begin
      @(negedge sysclk);
      checkOutput($sformatf("t3_ready_%0d", k), 32'(wr_ready), 32'((k <= FIFO_DEPTH) || (k == BYTE_CYC + 2)));
      ok = (wr_ready === 1'b1);
      tick();
      if (ok) begin
        exp_q.push_back({wr_dc, wr_data});
        model_sent++;
        acc++;
        wr_dc   = 1'($urandom);
        wr_data = 8'($urandom);
      end
    end
    wr_valid = 1'b0;
    checkOutput("t3_accepted", acc, FIFO_DEPTH + 2);
    waitIdle("t3");
    tick();
    compareStream("t3");

    // Reset mid-byte, then a clean transfer.
    seg_rises = 0;
    applyStimulus(1'b0, 8'h3C, ok);
    wr_valid = 1'b0;
    n = 0;
    @(negedge sysclk);
    while (seg_rises < 3 && n < 200) begin
      tick();
      @(negedge sysclk);
      n++;
    end
    checkOutput("t4_three_bits", seg_rises, 3);
    tick();
    applyReset();
    @(negedge sysclk);
    checkResetState("t4_rst");
`ifdef OLED_PWRSEQ_EN
    repeat (3 * PWR_WAIT) tick();
`else
    tick();
`endif
    applyStimulus(1'b1, 8'h55, ok);
    wr_valid = 1'b0;
    waitIdle("t4");
    tick();
    compareStream("t4");

    // Randomized bytes with random idle gaps, some longer than a byte period.
    seg_rises = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom), 8'($urandom), ok);
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(1, 40)) tick();
      end
    end
    wr_valid = 1'b0;
    waitIdle("rand");
    checkOutput("rand_rises", seg_rises, 8 * 24);
    tick();
    compareStream("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
